te_window_feeder: RTL and testbench

- Reader at the consumer end of the CVA6 commit FIFO.
- Pops `mure_pkg::fifo_entry_s` records and keeps a 3-deep sliding window: last cycle (lc), this cycle (tc) and next cycle (nc).
- The window feeds the instruction-type detection stage.
- When the commit stream goes idle, it shifts bubbles in, so the final committed instruction still reaches tc with a valid lc/nc context.

---
 rtl/te_window_feeder.sv | 122 ++++++++++++
 tb/tb_te_window_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/te_window_feeder.sv
// Commit-FIFO reader feeding a 3-entry sliding window (last/this/next cycle)
// to instruction-type detection; drains bubbles when the commit stream idles.
package mure_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  itype;
    logic [31:0] pc;
    logic [31:0] insn;
  } fifo_entry_s;
endpackage

module te_window_feeder #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned ENTRY_W      = $bits(mure_pkg::fifo_entry_s)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ENTRY_W-1:0] fifo_entry_i,
  input  logic               fifo_empty_i,
  output logic               fifo_pop_o,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [ENTRY_W-1:0] lc_fifo_entry_o,
  output logic [ENTRY_W-1:0] tc_fifo_entry_o,
  output logic [ENTRY_W-1:0] nc_fifo_entry_o,
  output logic               tc_new_o,
  output logic               draining_o
);

  localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                  r_state, w_state_nxt;
  logic [3:0]              r_idle_cnt, w_idle_cnt_nxt;
  mure_pkg::fifo_entry_s   r_lc, r_tc, r_nc;
  mure_pkg::fifo_entry_s   w_head, w_push;
  logic                    r_tc_new, w_tc_new_nxt;
  logic                    w_pop, w_shift, w_clear;

  assign w_head = mure_pkg::fifo_entry_s'(fifo_entry_i);
  assign w_pop  = rst_ni & ~fifo_empty_i & ~stall_i & ~flush_i;

  // Next-state: flush beats stall, a real pop beats a drain bubble.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_shift        = 1'b0;
    w_clear        = 1'b0;
    w_push         = '0;
    w_tc_new_nxt   = 1'b0;
    if (flush_i) begin
      w_clear        = 1'b1;
      w_state_nxt    = ST_IDLE;
      w_idle_cnt_nxt = '0;
    end else if (!stall_i) begin
      if (w_pop) begin
        w_shift        = 1'b1;
        w_push         = w_head;
        w_push.valid   = 1'b1;
        w_push.itype   = '0;
        w_state_nxt    = ST_RUN;
        w_idle_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (r_idle_cnt == LP_DRAIN) w_state_nxt = ST_DRAIN;
            else                        w_idle_cnt_nxt = r_idle_cnt + 4'd1;
          end
          ST_DRAIN: begin
            w_shift = 1'b1;
            // After this bubble the window is {tc, nc, bubble}.
            if (!r_tc.valid && !r_nc.valid) begin
              w_state_nxt    = ST_IDLE;
              w_idle_cnt_nxt = '0;
            end
          end
          default: w_idle_cnt_nxt = '0;
        endcase
      end
    end
    w_tc_new_nxt = w_shift & r_nc.valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lc     <= '0;
      r_tc     <= '0;
      r_nc     <= '0;
      r_tc_new <= 1'b0;
    end else begin
      r_tc_new <= w_tc_new_nxt;
      if (w_clear) begin
        r_lc <= '0;
        r_tc <= '0;
        r_nc <= '0;
      end else if (w_shift) begin
        r_lc <= r_tc;
        r_tc <= r_nc;
        r_nc <= w_push;
      end
    end
  end

  assign fifo_pop_o      = w_pop;
  assign lc_fifo_entry_o = r_lc;
  assign tc_fifo_entry_o = r_tc;
  assign nc_fifo_entry_o = r_nc;
  assign tc_new_o        = r_tc_new;
  assign draining_o      = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_te_window_feeder.sv
// Bench for te_window_feeder: directed vector table, async-reset sequence,
// then randomized traffic against a queue-based window model.
module tb_te_window_feeder;
  import mure_pkg::*;

  localparam int          DC = 4;
  localparam int          EW = $bits(fifo_entry_s);
  localparam logic [31:0] A  = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [EW-1:0] fifo_entry;
  logic          fifo_empty, stall, flush;
  logic          pop, tc_new, draining;
  logic [EW-1:0] lc, tc, nc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  te_window_feeder #(.DRAIN_CYCLES(DC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fifo_entry_i(fifo_entry),
    .fifo_empty_i(fifo_empty), .fifo_pop_o(pop), .stall_i(stall),
    .flush_i(flush), .lc_fifo_entry_o(lc), .tc_fifo_entry_o(tc),
    .nc_fifo_entry_o(nc), .tc_new_o(tc_new), .draining_o(draining)
  );

  typedef struct {
    logic        e, s, f;
    logic [31:0] pc;
    logic        pop;
    logic [2:0]  vld;
    logic [31:0] lc, tc, nc;
    logic        nw, dr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(logic e, logic s, logic f, logic [31:0] pc,
                               logic p, logic [2:0] v, logic [31:0] l,
                               logic [31:0] t, logic [31:0] n, logic nw, logic dr);
    vec_t x;
    x.e = e; x.s = s; x.f = f; x.pc = pc; x.pop = p; x.vld = v;
    x.lc = l; x.tc = t; x.nc = n; x.nw = nw; x.dr = dr;
    return x;
  endfunction

  function automatic fifo_entry_s drive_ent(logic [31:0] pc);
    fifo_entry_s x;
    x.valid = 1'b0; x.itype = 4'hA; x.pc = pc; x.insn = ~pc;
    return x;
  endfunction

  function automatic fifo_entry_s exp_ent(logic [31:0] pc, logic v);
    fifo_entry_s x = '0;
    if (v) begin x.valid = 1'b1; x.pc = pc; x.insn = ~pc; end
    return x;
  endfunction

  task automatic chk(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: window as a 3-slot queue (index 0 = lc).
  fifo_entry_s mw[$];
  logic        m_new, m_live, m_drain;
  int          m_idle;

  task automatic model_clear();
    mw.delete();
    for (int i = 0; i < 3; i++) mw.push_back('0);
    m_new = 1'b0; m_live = 1'b0; m_drain = 1'b0; m_idle = 0;
  endtask

  task automatic model_shift(fifo_entry_s x);
    m_new = mw[2].valid;
    void'(mw.pop_front());
    mw.push_back(x);
  endtask

  task automatic model_step(logic e, logic s, logic f, fifo_entry_s ent);
    fifo_entry_s forced;
    int nvalid;
    forced = ent; forced.valid = 1'b1; forced.itype = '0;
    if (f) begin
      model_clear();
    end else if (s) begin
      m_new = 1'b0;
    end else if (!e) begin
      model_shift(forced);
      m_live = 1'b1; m_drain = 1'b0; m_idle = 0;
    end else if (m_drain) begin
      model_shift('0);
      nvalid = 0;
      foreach (mw[i]) nvalid += int'(mw[i].valid);
      if (nvalid == 0) begin m_drain = 1'b0; m_live = 1'b0; m_idle = 0; end
    end else begin
      m_new = 1'b0;
      if (m_live) begin
        if (m_idle == DC) m_drain = 1'b1;
        else              m_idle++;
      end
    end
  endtask

  initial begin
    logic        e, s, f;
    fifo_entry_s ent;
    int          burst;

    // Directed table: fill, stall, drain, pop-in-drain, flush, pop at drain entry.
    vq.push_back(mkv(0,0,0,A+0,   1,3'b001,0,0,A+0, 0,0));
    vq.push_back(mkv(0,0,0,A+4,   1,3'b011,0,A+0,A+4, 1,0));
    vq.push_back(mkv(0,0,0,A+8,   1,3'b111,A+0,A+4,A+8, 1,0));
    for (int i = 0; i < 5; i++) vq.push_back(mkv(0,1,0,A+12, 0,3'b111,A+0,A+4,A+8, 0,0));
    vq.push_back(mkv(0,0,0,A+12,  1,3'b111,A+4,A+8,A+12, 1,0));
    for (int i = 0; i < 4; i++) vq.push_back(mkv(1,0,0,0, 0,3'b111,A+4,A+8,A+12, 0,0));
    vq.push_back(mkv(1,0,0,0,     0,3'b111,A+4,A+8,A+12, 0,1));
    vq.push_back(mkv(1,0,0,0,     0,3'b110,A+8,A+12,0, 1,1));
    vq.push_back(mkv(1,0,0,0,     0,3'b100,A+12,0,0, 0,1));
    vq.push_back(mkv(1,0,0,0,     0,3'b000,0,0,0, 0,0));
    vq.push_back(mkv(1,0,0,0,     0,3'b000,0,0,0, 0,0));
    vq.push_back(mkv(0,0,0,A+16,  1,3'b001,0,0,A+16, 0,0));
    vq.push_back(mkv(0,0,0,A+20,  1,3'b011,0,A+16,A+20, 1,0));
    vq.push_back(mkv(0,0,0,A+24,  1,3'b111,A+16,A+20,A+24, 1,0));
    for (int i = 0; i < 4; i++) vq.push_back(mkv(1,0,0,0, 0,3'b111,A+16,A+20,A+24, 0,0));
    vq.push_back(mkv(1,0,0,0,     0,3'b111,A+16,A+20,A+24, 0,1));
    vq.push_back(mkv(1,0,0,0,     0,3'b110,A+20,A+24,0, 1,1));
    vq.push_back(mkv(0,0,0,A+256, 1,3'b101,A+24,0,A+256, 0,0));
    for (int i = 0; i < 4; i++) vq.push_back(mkv(1,0,0,0, 0,3'b101,A+24,0,A+256, 0,0));
    vq.push_back(mkv(1,0,0,0,     0,3'b101,A+24,0,A+256, 0,1));
    vq.push_back(mkv(0,0,0,A+260, 1,3'b011,0,A+256,A+260, 1,0));
    vq.push_back(mkv(0,0,1,A+264, 0,3'b000,0,0,0, 0,0));
    vq.push_back(mkv(0,0,0,A+264, 1,3'b001,0,0,A+264, 0,0));
    vq.push_back(mkv(0,1,1,A+268, 0,3'b000,0,0,0, 0,0));
    vq.push_back(mkv(0,0,0,A+268, 1,3'b001,0,0,A+268, 0,0));
    for (int i = 0; i < 4; i++) vq.push_back(mkv(1,0,0,0, 0,3'b001,0,0,A+268, 0,0));
    vq.push_back(mkv(0,0,0,A+272, 1,3'b011,0,A+268,A+272, 1,0));
    vq.push_back(mkv(1,0,0,0,     0,3'b011,0,A+268,A+272, 0,0));

    rst_n = 1'b0; fifo_empty = 1'b0; stall = 1'b0; flush = 1'b0;
    fifo_entry = drive_ent(A);
    #3;
    chk1("reset pop", pop, 1'b0);
    chk("reset lc", lc, '0);
    chk("reset tc", tc, '0);
    chk("reset nc", nc, '0);
    chk1("reset tc_new", tc_new, 1'b0);
    chk1("reset draining", draining, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; fifo_empty = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      fifo_empty = vq[i].e; stall = vq[i].s; flush = vq[i].f;
      fifo_entry = drive_ent(vq[i].pc);
      #1 chk1($sformatf("v%0d pop", i), pop, vq[i].pop);
      @(posedge clk); #1;
      chk($sformatf("v%0d lc", i), lc, exp_ent(vq[i].lc, vq[i].vld[2]));
      chk($sformatf("v%0d tc", i), tc, exp_ent(vq[i].tc, vq[i].vld[1]));
      chk($sformatf("v%0d nc", i), nc, exp_ent(vq[i].nc, vq[i].vld[0]));
      chk1($sformatf("v%0d tc_new", i), tc_new, vq[i].nw);
      chk1($sformatf("v%0d draining", i), draining, vq[i].dr);
    end

    // Asynchronous reset between edges while running with a full window.
    @(negedge clk);
    fifo_empty = 1'b0; fifo_entry = drive_ent(A+276);
    @(posedge clk); #1;
    chk1("pre-reset tc_new", tc_new, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async lc", lc, '0);
    chk("async tc", tc, '0);
    chk("async nc", nc, '0);
    chk1("async tc_new", tc_new, 1'b0);
    chk1("async pop", pop, 1'b0);
    @(posedge clk); #1;
    chk1("held reset pop", pop, 1'b0);
    chk("held reset nc", nc, '0);
    @(negedge clk);
    rst_n = 1'b1; fifo_entry = drive_ent(A+512);
    #1 chk1("post-reset pop", pop, 1'b1);
    @(posedge clk); #1;
    chk("post-reset lc", lc, '0);
    chk("post-reset tc", tc, '0);
    chk("post-reset nc", nc, exp_ent(A+512, 1'b1));

    model_clear();
    mw[2] = exp_ent(A+512, 1'b1);
    m_live = 1'b1;

    // Randomized traffic in bursts so idle stretches reach the drain.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 24 == 0) burst = int'($urandom_range(0, 2));
      @(negedge clk);
      case (burst)
        0:       e = ($urandom_range(0, 9) != 0);
        1:       e = ($urandom_range(0, 9) == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      s = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 59) == 0);
      ent.valid = 1'($urandom_range(0, 1));
      ent.itype = 4'($urandom);
      ent.pc    = $urandom;
      ent.insn  = $urandom;
      fifo_empty = e; stall = s; flush = f; fifo_entry = ent;
      #1 chk1($sformatf("r%0d pop", c), pop, !e && !s && !f);
      model_step(e, s, f, ent);
      @(posedge clk); #1;
      chk($sformatf("r%0d lc", c), lc, mw[0]);
      chk($sformatf("r%0d tc", c), tc, mw[1]);
      chk($sformatf("r%0d nc", c), nc, mw[2]);
      chk1($sformatf("r%0d tc_new", c), tc_new, m_new);
      chk1($sformatf("r%0d draining", c), draining, m_drain);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
